// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared encodings for the flush/redirect sequencer:
// cause codes, FSM state codes and the sequential-PC step.
package flush_redirect_ctrl_pkg;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_EXCP    = 3'd1;
    localparam logic [2:0] CAUSE_ERTN    = 3'd2;
    localparam logic [2:0] CAUSE_ICACOP  = 3'd3;
    localparam logic [2:0] CAUSE_IDLE    = 3'd4;
    localparam logic [2:0] CAUSE_REFETCH = 3'd5;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_OP  = 2'd2;
    localparam logic [1:0] ST_WAIT_INT = 2'd3;

    localparam logic [31:0] PC_INC = 32'd4;

    // Next sequential PC, wrapping modulo 2^32.
    function automatic logic [31:0] seq_pc(
        input logic [31:0] pc
    );
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/flush_redirect_ctrl_prio.sv
// flush_prio_enc: fixed-priority encoder over the five flush bits.
// In: excp/ertn/icacop/idle/refetch flush. Out: cause code, one-hot grant
// (grant[0]=excp .. grant[4]=refetch).
module flush_prio_enc
    import flush_redirect_ctrl_pkg::*;
(
    input  logic       excp_flush,
    input  logic       ertn_flush,
    input  logic       icacop_flush,
    input  logic       idle_flush,
    input  logic       refetch_flush,
    output logic [2:0] cause,
    output logic [4:0] grant
);

    always_comb begin
        cause = CAUSE_NONE;
        grant = 5'b00000;
        if (excp_flush) begin
            cause = CAUSE_EXCP;
            grant = 5'b00001;
        end else if (ertn_flush) begin
            cause = CAUSE_ERTN;
            grant = 5'b00010;
        end else if (icacop_flush) begin
            cause = CAUSE_ICACOP;
            grant = 5'b00100;
        end else if (idle_flush) begin
            cause = CAUSE_IDLE;
            grant = 5'b01000;
        end else if (refetch_flush) begin
            cause = CAUSE_REFETCH;
            grant = 5'b10000;
        end
    end

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer between writeback and fetch: arbitrates flushes,
// holds the redirect PC/cause, waits on icache ops and IDLE, stalls upstream.
// In:  clk, resetn, *_flush, excp_tlbrefill, ws_pc, csr_*, has_int,
//      icacop_done, redirect_ready.
// Out: redirect_valid/pc/cause, pipe_hold, idle_active, op_timeout_err,
//      stat_redirect_cnt, stat_idle_cycles.
// Optional counters: define FLUSH_REDIRECT_CTRL_STAT_EN (else tied to 0).
module flush_redirect_ctrl
    import flush_redirect_ctrl_pkg::*;
#(
    parameter int OP_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic        refetch_flush,
    input  logic        icacop_flush,
    input  logic        idle_flush,
    input  logic        excp_tlbrefill,
    input  logic [31:0] ws_pc,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era_q,
    input  logic        has_int,
    input  logic        icacop_done,
    input  logic        redirect_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [2:0]  redirect_cause,
    output logic        pipe_hold,
    output logic        idle_active,
    output logic        op_timeout_err,
    output logic [31:0] stat_redirect_cnt,
    output logic [31:0] stat_idle_cycles
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [2:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [2:0]  win_cause;
    logic [4:0]  win_grant;
    logic        any_flush;
    logic [31:0] flush_tgt;

    flush_prio_enc u_prio (
        .excp_flush    (excp_flush),
        .ertn_flush    (ertn_flush),
        .icacop_flush  (icacop_flush),
        .idle_flush    (idle_flush),
        .refetch_flush (refetch_flush),
        .cause         (win_cause),
        .grant         (win_grant)
    );

    assign any_flush = |win_grant;

    always_comb begin
        flush_tgt = seq_pc(ws_pc);
        if (win_grant[0]) begin
            flush_tgt = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
        end else if (win_grant[1]) begin
            flush_tgt = csr_era_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (any_flush) begin
                    pc_d    = flush_tgt;
                    cause_d = win_cause;
                    cnt_d   = '0;
                    if (win_grant[2]) begin
                        state_d = ST_WAIT_OP;
                    end else if (win_grant[3]) begin
                        state_d = ST_WAIT_INT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (redirect_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT_OP: begin
                // Timeout fires on the OP_TIMEOUT-th cycle spent here.
                if (icacop_done) begin
                    state_d = ST_ISSUE;
                end else if (cnt_q == CNT_W'(OP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_INT: begin
                if (has_int) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign redirect_valid = (state_q == ST_ISSUE);
    assign redirect_pc    = pc_q;
    assign redirect_cause = cause_q;
    assign pipe_hold      = (state_q != ST_RUN);
    assign idle_active    = (state_q == ST_WAIT_INT);
    assign op_timeout_err = err_q;

`ifdef FLUSH_REDIRECT_CTRL_STAT_EN
    logic [31:0] redir_cnt_q;
    logic [31:0] idle_cnt_q;
    logic        hs;

    assign hs = redirect_valid && redirect_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            if (hs && (redir_cnt_q != 32'hFFFF_FFFF)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
            if (idle_active && (idle_cnt_q != 32'hFFFF_FFFF)) begin
                idle_cnt_q <= idle_cnt_q + 32'd1;
            end
        end
    end

    assign stat_redirect_cnt = redir_cnt_q;
    assign stat_idle_cycles  = idle_cnt_q;
`else
    assign stat_redirect_cnt = 32'd0;
    assign stat_idle_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Bench for flush_redirect_ctrl: scenario tasks plus a scoreboard
// that checks every redirect handshake against an independent model.
module tb_flush_redirect_ctrl;

    localparam int TMO = 64;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cause;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        excp_flush, ertn_flush, refetch_flush;
    logic        icacop_flush, idle_flush, excp_tlbrefill;
    logic [31:0] ws_pc, csr_eentry, csr_tlbrentry, csr_era_q;
    logic        has_int, icacop_done, redirect_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  redirect_cause;
    logic        pipe_hold, idle_active, op_timeout_err;
    logic [31:0] stat_redirect_cnt, stat_idle_cycles;

    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    flush_redirect_ctrl #(.OP_TIMEOUT(64), .CNT_W(7)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush),
        .refetch_flush     (refetch_flush),
        .icacop_flush      (icacop_flush),
        .idle_flush        (idle_flush),
        .excp_tlbrefill    (excp_tlbrefill),
        .ws_pc             (ws_pc),
        .csr_eentry        (csr_eentry),
        .csr_tlbrentry     (csr_tlbrentry),
        .csr_era_q         (csr_era_q),
        .has_int           (has_int),
        .icacop_done       (icacop_done),
        .redirect_ready    (redirect_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_cause    (redirect_cause),
        .pipe_hold         (pipe_hold),
        .idle_active       (idle_active),
        .op_timeout_err    (op_timeout_err),
        .stat_redirect_cnt (stat_redirect_cnt),
        .stat_idle_cycles  (stat_idle_cycles)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic e, input logic r, input logic i,
        input logic d, input logic f, input logic tlb,
        input logic [31:0] pc, input logic [31:0] ee,
        input logic [31:0] tr, input logic [31:0] era
    );
        exp_t x;
        x.pc    = pc + 32'd4;
        x.cause = 3'd0;
        if (e) begin
            x.pc    = tlb ? tr : ee;
            x.cause = 3'd1;
        end else if (r) begin
            x.pc    = era;
            x.cause = 3'd2;
        end else if (i) begin
            x.cause = 3'd3;
        end else if (d) begin
            x.cause = 3'd4;
        end else if (f) begin
            x.cause = 3'd5;
        end
        return x;
    endfunction

    // Scoreboard: every handshake must match the oldest expected redirect.
    always @(negedge clk) begin
        if (resetn) begin
            if (redirect_valid && redirect_ready) begin
                exp_t x;
                hs_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: pc=%h cause=%0d no redirect expected",
                             redirect_pc, redirect_cause);
                end else begin
                    x = sb_q.pop_front();
                    if (redirect_pc !== x.pc || redirect_cause !== x.cause) begin
                        errors++;
                        $display("FAIL sb_redirect: got pc=%h cause=%0d want pc=%h cause=%0d",
                                 redirect_pc, redirect_cause, x.pc, x.cause);
                    end
                end
            end
            if (pipe_hold && (excp_flush | ertn_flush | refetch_flush |
                              icacop_flush | idle_flush)) begin
                errors++;
                checks++;
                $display("FAIL protocol: flush driven while pipe_hold=1");
            end
        end
    end

    task automatic clear_flush();
        excp_flush     = 1'b0;
        ertn_flush     = 1'b0;
        refetch_flush  = 1'b0;
        icacop_flush   = 1'b0;
        idle_flush     = 1'b0;
        excp_tlbrefill = 1'b0;
    endtask

    task automatic drive_flush(
        input logic e, input logic r, input logic i,
        input logic d, input logic f, input logic tlb,
        input logic [31:0] pc
    );
        excp_flush     = e;
        ertn_flush     = r;
        icacop_flush   = i;
        idle_flush     = d;
        refetch_flush  = f;
        excp_tlbrefill = tlb;
        ws_pc          = pc;
        last_exp = model(e, r, i, d, f, tlb, pc,
                         csr_eentry, csr_tlbrentry, csr_era_q);
        sb_q.push_back(last_exp);
        @(posedge clk); #1;
        clear_flush();
    endtask

    task automatic complete_handshake(input string name);
        int n = 0;
        while (!redirect_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!redirect_valid) begin
            errors++;
            checks++;
            $display("FAIL %s_wait: redirect_valid never rose", name);
        end
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        checks++;
        if (redirect_valid !== 1'b0 || pipe_hold !== 1'b0) begin
            errors++;
            $display("FAIL %s_drop: valid=%b hold=%b want 0 0",
                     name, redirect_valid, pipe_hold);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 ||
            redirect_cause !== 3'd0 || pipe_hold !== 1'b0 ||
            idle_active !== 1'b0 || op_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: v=%b pc=%h c=%0d h=%b i=%b e=%b want all 0",
                     redirect_valid, redirect_pc, redirect_cause,
                     pipe_hold, idle_active, op_timeout_err);
        end
        checks++;
        if (stat_redirect_cnt !== 32'd0 || stat_idle_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d %0d want 0 0",
                     stat_redirect_cnt, stat_idle_cycles);
        end
    endtask

    task automatic test_exception();
        csr_eentry = 32'h1C00_8000;
        drive_flush(1, 0, 0, 0, 0, 0, 32'h1C00_0040);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 ||
            redirect_cause !== 3'd1) begin
            errors++;
            $display("FAIL excp_issue: v=%b pc=%h c=%0d want 1 1c008000 1",
                     redirect_valid, redirect_pc, redirect_cause);
        end
        for (int k = 0; k < 3; k++) begin
            csr_eentry = 32'hDEAD_0000 + k;
            @(posedge clk); #1;
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 ||
                pipe_hold !== 1'b1) begin
                errors++;
                $display("FAIL excp_stall: v=%b pc=%h h=%b want 1 1c008000 1",
                         redirect_valid, redirect_pc, pipe_hold);
            end
        end
        complete_handshake("excp");
    endtask

    task automatic test_priority();
        int h0 = hs_cnt;
        csr_tlbrentry = 32'h1C00_F000;
        csr_era_q     = 32'h1C00_2000;
        excp_flush    = 1'b1;
        ertn_flush    = 1'b1;
        drive_flush(1, 1, 0, 0, 1, 1, 32'h1C00_0080);
        checks++;
        if (redirect_pc !== 32'h1C00_F000 || redirect_cause !== 3'd1) begin
            errors++;
            $display("FAIL prio_win: pc=%h c=%0d want 1c00f000 1",
                     redirect_pc, redirect_cause);
        end
        complete_handshake("prio");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (hs_cnt - h0 !== 1 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_single: handshakes=%0d valid=%b want 1 0",
                     hs_cnt - h0, redirect_valid);
        end
    endtask

    task automatic test_prio_table();
        logic [4:0] tbl [6];
        int h0 = hs_cnt;
        tbl[0] = 5'b01001;
        tbl[1] = 5'b00111;
        tbl[2] = 5'b00011;
        tbl[3] = 5'b00001;
        tbl[4] = 5'b01111;
        tbl[5] = 5'b10000;
        for (int k = 0; k < 6; k++) begin
            logic [4:0] v;
            v = tbl[k];
            csr_era_q  = 32'h1C00_A000 + 32'(k * 16);
            csr_eentry = 32'h1C00_B000 + 32'(k * 16);
            drive_flush(v[4], v[3], v[2], v[1], v[0], 1'b0,
                        32'h1C00_1000 + 32'(k * 4));
            if (last_exp.cause == 3'd3) begin
                icacop_done = 1'b1;
                @(posedge clk); #1;
                icacop_done = 1'b0;
            end else if (last_exp.cause == 3'd4) begin
                has_int = 1'b1;
                @(posedge clk); #1;
                has_int = 1'b0;
            end
            complete_handshake("table");
        end
        checks++;
        if (hs_cnt - h0 !== 6 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL table_count: handshakes=%0d pending=%0d want 6 0",
                     hs_cnt - h0, sb_q.size());
        end
    endtask

    task automatic test_icacop();
        int bad = 0;
        drive_flush(0, 0, 1, 0, 0, 0, 32'h1C00_0100);
        for (int k = 0; k < 10; k++) begin
            if (pipe_hold !== 1'b1 || redirect_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL icacop_hold: %0d bad cycles want 0", bad);
        end
        icacop_done = 1'b1;
        @(posedge clk); #1;
        icacop_done = 1'b0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0104 ||
            redirect_cause !== 3'd3 || op_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL icacop_issue: v=%b pc=%h c=%0d err=%b want 1 1c000104 3 0",
                     redirect_valid, redirect_pc, redirect_cause, op_timeout_err);
        end
        complete_handshake("icacop");
    endtask

    task automatic test_timeout();
        int n = 0;
        drive_flush(0, 0, 1, 0, 0, 0, 32'h1C00_0300);
        while (!redirect_valid && n < 200) begin
            if (n == 10) begin
                checks++;
                if (op_timeout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_early: err=%b want 0", op_timeout_err);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != TMO || op_timeout_err !== 1'b1 ||
            redirect_pc !== 32'h1C00_0304) begin
            errors++;
            $display("FAIL tmo_fire: cycles=%0d err=%b pc=%h want %0d 1 1c000304",
                     n, op_timeout_err, redirect_pc, TMO);
        end
        complete_handshake("tmo");
        checks++;
        if (op_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: err=%b want 1", op_timeout_err);
        end
    endtask

    task automatic test_wrap();
        drive_flush(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
        checks++;
        if (redirect_pc !== 32'h0000_0000 || redirect_cause !== 3'd5) begin
            errors++;
            $display("FAIL wrap: pc=%h c=%0d want 00000000 5",
                     redirect_pc, redirect_cause);
        end
        complete_handshake("wrap");
    endtask

    task automatic test_idle();
        int act = 0;
        logic [31:0] r0 = stat_redirect_cnt;
        logic [31:0] i0 = stat_idle_cycles;
        drive_flush(0, 0, 0, 1, 0, 0, 32'h1C00_0200);
        for (int k = 0; k < 20; k++) begin
            if (idle_active === 1'b1 && redirect_valid === 1'b0) act++;
            if (k == 19) has_int = 1'b1;
            @(posedge clk); #1;
        end
        has_int = 1'b0;
        checks++;
        if (act != 20 || idle_active !== 1'b0 || redirect_valid !== 1'b1 ||
            redirect_pc !== 32'h1C00_0204) begin
            errors++;
            $display("FAIL idle_wait: active=%0d idle=%b v=%b pc=%h want 20 0 1 1c000204",
                     act, idle_active, redirect_valid, redirect_pc);
        end
        complete_handshake("idle");
`ifdef FLUSH_REDIRECT_CTRL_STAT_EN
        checks++;
        if (stat_idle_cycles - i0 !== 32'd20 ||
            stat_redirect_cnt - r0 !== 32'd1) begin
            errors++;
            $display("FAIL idle_stats: idle=%0d redir=%0d want 20 1",
                     stat_idle_cycles - i0, stat_redirect_cnt - r0);
        end
`else
        checks++;
        if (stat_idle_cycles !== 32'd0 || stat_redirect_cnt !== 32'd0 ||
            r0 !== 32'd0 || i0 !== 32'd0) begin
            errors++;
            $display("FAIL idle_stats_off: idle=%0d redir=%0d want 0 0",
                     stat_idle_cycles, stat_redirect_cnt);
        end
`endif
    endtask

    task automatic test_idle_early_int();
        has_int = 1'b1;
        drive_flush(0, 0, 0, 1, 0, 0, 32'h1C00_0400);
        checks++;
        if (idle_active !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_early_wait: idle=%b v=%b want 1 0",
                     idle_active, redirect_valid);
        end
        @(posedge clk); #1;
        has_int = 1'b0;
        checks++;
        if (idle_active !== 1'b0 || redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_early_issue: idle=%b v=%b want 0 1",
                     idle_active, redirect_valid);
        end
        complete_handshake("idle_early");
    endtask

    task automatic test_ignored();
        int h0 = hs_cnt;
        icacop_done    = 1'b1;
        redirect_ready = 1'b1;
        has_int        = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        icacop_done    = 1'b0;
        redirect_ready = 1'b0;
        has_int        = 1'b0;
        checks++;
        if (pipe_hold !== 1'b0 || redirect_valid !== 1'b0 ||
            idle_active !== 1'b0 || hs_cnt != h0) begin
            errors++;
            $display("FAIL ignored: h=%b v=%b i=%b hs=%0d want 0 0 0 0",
                     pipe_hold, redirect_valid, idle_active, hs_cnt - h0);
        end
    endtask

    task automatic test_reset_mid_idle();
        int bad = 0;
        drive_flush(0, 0, 0, 1, 0, 0, 32'h1C00_0500);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 ||
            redirect_cause !== 3'd0 || pipe_hold !== 1'b0 ||
            idle_active !== 1'b0 || op_timeout_err !== 1'b0 ||
            stat_redirect_cnt !== 32'd0 || stat_idle_cycles !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: v=%b pc=%h c=%0d h=%b i=%b e=%b want all 0",
                     redirect_valid, redirect_pc, redirect_cause,
                     pipe_hold, idle_active, op_timeout_err);
        end
        sb_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        redirect_ready = 1'b1;
        has_int = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (redirect_valid !== 1'b0 || pipe_hold !== 1'b0) bad++;
        end
        redirect_ready = 1'b0;
        has_int = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_after: %0d cycles with redirect/hold want 0", bad);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        clear_flush();
        ws_pc          = 32'd0;
        csr_eentry     = 32'd0;
        csr_tlbrentry  = 32'd0;
        csr_era_q      = 32'd0;
        has_int        = 1'b0;
        icacop_done    = 1'b0;
        redirect_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_exception();
        test_priority();
        test_prio_table();
        test_icacop();
        test_timeout();
        test_wrap();
        test_idle();
        test_idle_early_int();
        test_ignored();
        test_reset_mid_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
